// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared constants, state type and helpers for the round-robin arbiter
package rr_arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [NREQ-1:0] GNT0 = 4'b0001;
    localparam logic [NREQ-1:0] GNT1 = 4'b0010;
    localparam logic [NREQ-1:0] GNT2 = 4'b0100;
    localparam logic [NREQ-1:0] GNT3 = 4'b1000;

    function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [1:0] idx;
        case (oh)
            GNT1:    idx = 2'd1;
            GNT2:    idx = 2'd2;
            GNT3:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // True for zero or exactly one bit set.
    function automatic logic is_onehot0(input logic [NREQ-1:0] v);
        return (v & (v - 4'd1)) == 4'd0;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority pick starting at ptr
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    input  logic [NREQ-1:0] excl_mask,
    output logic [NREQ-1:0] win_onehot,
    output logic [1:0]      win_idx,
    output logic            any
);

    logic [NREQ-1:0] w_masked;
    logic [1:0]      w_idx;

    always_comb begin
        w_masked   = req & ~excl_mask;
        w_idx      = '0;
        win_onehot = '0;
        win_idx    = '0;
        any        = 1'b0;
        // The 2-bit index wraps naturally, giving the modulo-4 rotation.
        for (int i = 0; i < NREQ; i++) begin
            w_idx = ptr + 2'(i);
            if (!any && w_masked[w_idx]) begin
                any        = 1'b1;
                win_idx    = w_idx;
                win_onehot = 4'b0001 << w_idx;
            end
        end
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// rtl/rr_onehot_arbiter.sv - four-way round-robin arbiter with registered one-hot grant and burst cap
module rr_onehot_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CW        = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [1:0]      grant_idx,
    output logic            grant_valid,
    output logic [CW-1:0]   burst_cnt
);

    state_t          r_state;
    logic [NREQ-1:0] r_grant;
    logic [1:0]      r_grant_idx;
    logic            r_grant_valid;
    logic [CW-1:0]   r_burst_cnt;
    logic [1:0]      r_ptr;

    state_t          w_nxt_state;
    logic [NREQ-1:0] w_nxt_grant;
    logic [1:0]      w_nxt_grant_idx;
    logic            w_nxt_grant_valid;
    logic [CW-1:0]   w_nxt_burst_cnt;
    logic [1:0]      w_nxt_ptr;

    logic [NREQ-1:0] w_excl;
    logic [NREQ-1:0] w_win_onehot;
    logic [1:0]      w_win_idx;
    logic            w_any;
    logic            w_tenure_end;

    // The current owner is never a handover candidate.
    assign w_excl       = (r_state == GRANT) ? r_grant : '0;
    assign w_tenure_end = !req[r_grant_idx] || (r_burst_cnt == CW'(MAX_BURST));

    rr_pick u_pick (
        .req        (req),
        .ptr        (r_ptr),
        .excl_mask  (w_excl),
        .win_onehot (w_win_onehot),
        .win_idx    (w_win_idx),
        .any        (w_any)
    );

    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_grant       = r_grant;
        w_nxt_grant_idx   = r_grant_idx;
        w_nxt_grant_valid = r_grant_valid;
        w_nxt_burst_cnt   = r_burst_cnt;
        w_nxt_ptr         = r_ptr;

        if (!is_onehot0(r_grant)) begin
            w_nxt_state       = IDLE;
            w_nxt_grant       = '0;
            w_nxt_grant_idx   = '0;
            w_nxt_grant_valid = 1'b0;
            w_nxt_burst_cnt   = '0;
        end else if (r_state == IDLE || w_tenure_end) begin
            if (w_any) begin
                w_nxt_state       = GRANT;
                w_nxt_grant       = w_win_onehot;
                w_nxt_grant_idx   = onehot_to_idx(w_win_onehot);
                w_nxt_grant_valid = 1'b1;
                w_nxt_burst_cnt   = CW'(1);
                w_nxt_ptr         = w_win_idx + 2'd1;
            end else if (r_state == GRANT && req[r_grant_idx]) begin
                w_nxt_burst_cnt   = CW'(1);
            end else begin
                w_nxt_state       = IDLE;
                w_nxt_grant       = '0;
                w_nxt_grant_idx   = '0;
                w_nxt_grant_valid = 1'b0;
                w_nxt_burst_cnt   = '0;
            end
        end else begin
            w_nxt_burst_cnt = r_burst_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_burst_cnt   <= '0;
            r_ptr         <= '0;
        end else begin
            r_state       <= w_nxt_state;
            r_grant       <= w_nxt_grant;
            r_grant_idx   <= w_nxt_grant_idx;
            r_grant_valid <= w_nxt_grant_valid;
            r_burst_cnt   <= w_nxt_burst_cnt;
            r_ptr         <= w_nxt_ptr;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign burst_cnt   = r_burst_cnt;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb/tb_rr_onehot_arbiter.sv - randomized and directed self-checking bench for rr_onehot_arbiter
module tb_rr_onehot_arbiter;

    localparam int MAXB = 4;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    req = 4'b0000;
    logic [3:0]    grant;
    logic [1:0]    grant_idx;
    logic          grant_valid;
    logic [CW-1:0] burst_cnt;

    int total = 0;
    int bad   = 0;

    int m_owner = -1;
    int m_cnt   = 0;
    int m_ptr   = 0;
    bit m_force = 1'b0;
    bit chk_en  = 1'b1;

    rr_onehot_arbiter #(.MAX_BURST(MAXB), .CW(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .burst_cnt   (burst_cnt)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int p, input int excl);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (p + i) % 4;
            if (r[k] && k != excl) return k;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner = -1;
            m_cnt   = 0;
            m_ptr   = 0;
        end else if (m_force) begin
            m_owner = -1;
            m_cnt   = 0;
            m_force = 1'b0;
        end else if (m_owner < 0) begin
            int w;
            w = pick(req, m_ptr, -1);
            if (w >= 0) begin
                m_owner = w;
                m_cnt   = 1;
                m_ptr   = (w + 1) % 4;
            end
        end else if (req[m_owner] && m_cnt < MAXB) begin
            m_cnt = m_cnt + 1;
        end else begin
            int w;
            w = pick(req, m_ptr, m_owner);
            if (w >= 0) begin
                m_owner = w;
                m_cnt   = 1;
                m_ptr   = (w + 1) % 4;
            end else if (req[m_owner]) begin
                m_cnt = 1;
            end else begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int eg;
            eg = (m_owner < 0) ? 0 : (1 << m_owner);
            check("model_grant", int'(grant), eg);
            check("model_idx", int'(grant_idx), (m_owner < 0) ? 0 : m_owner);
            check("model_valid", int'(grant_valid), (m_owner < 0) ? 0 : 1);
            check("model_cnt", int'(burst_cnt), m_cnt);
        end
    end

    task automatic tick(input logic [3:0] r);
        req = r;
        @(negedge clk);
    endtask

    initial begin
        int exp_cnt [10];
        logic [3:0] rr;
        exp_cnt = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2};

        req = 4'b1111;
        repeat (3) @(negedge clk);
        check("rst_grant", int'(grant), 0);
        check("rst_idx", int'(grant_idx), 0);
        check("rst_valid", int'(grant_valid), 0);
        check("rst_cnt", int'(burst_cnt), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            tick(4'b1111);
            check("rot_grant", int'(grant), 1 << ((i / 4) % 4));
            check("rot_cnt", int'(burst_cnt), (i % 4) + 1);
            if (i == 0) check("rot_ptr", int'(dut.r_ptr), 1);
        end
        tick(4'b0000);
        check("rot_idle", int'(grant), 0);

        for (int i = 0; i < 10; i++) begin
            tick(4'b0100);
            check("solo_grant", int'(grant), 4);
            check("solo_cnt", int'(burst_cnt), exp_cnt[i]);
        end
        tick(4'b0000);

        tick(4'b0010);
        check("drop_g1", int'(grant), 2);
        tick(4'b1010);
        check("drop_g1b", int'(burst_cnt), 2);
        tick(4'b1000);
        check("drop_hand", int'(grant), 8);
        tick(4'b0000);
        check("drop_idle", int'(grant), 0);

        tick(4'b1111);
        check("ar_g0", int'(grant), 1);
        tick(4'b1111);
        #2 reset_n = 1'b0;
        #1 check("ar_async", int'(grant), 0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("ar_restart", int'(grant), 1);

        tick(4'b1111);
        chk_en = 1'b0;
        #1 force dut.r_grant = 4'b0110;
        m_force = 1'b1;
        #1 release dut.r_grant;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("rec_grant", int'(grant), 0);
        check("rec_valid", int'(grant_valid), 0);
        check("rec_ptr", int'(dut.r_ptr), 1);
        tick(4'b1111);
        check("rec_next", int'(grant), 2);

        rr = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(3) == 0) rr[b] = ~rr[b];
            tick(rr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_onehot_arbiter.md
# rr_onehot_arbiter

Four-requester round-robin arbiter that shares one downstream resource (bus, memory port, sequencer slot) between requesters. It issues a registered one-hot grant and bounds each tenure to a programmable burst length, so a single requester cannot starve the others. It sits between requesting blocks and the shared resource and is the single point that decides ownership each cycle.

## Interface
- `MAX_BURST`, default 4: maximum consecutive grant cycles per tenure; legal range 1..15.
- `CW`, default 4: burst counter width; must hold `MAX_BURST`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req`  in  4  level request per requester; held high while the requester wants the resource.
- `grant`  out  4  registered one-hot grant, or 4'b0000 when no requester owns the resource.
- `grant_idx`  out  2  binary index of the current owner; 2'b00 when `grant` is zero.
- `grant_valid`  out  1  high when `grant` is nonzero.
- `burst_cnt`  out  CW  grant cycles consumed by the current tenure, 1..MAX_BURST; 0 when idle.

## Operation
- Reset values: `grant`=0, `grant_idx`=0, `grant_valid`=0, `burst_cnt`=0, priority pointer `ptr`=0, state IDLE.
- The two states are IDLE (no owner) and GRANT (one owner).
- Arbitration pick: starting from `ptr` and rotating upward modulo 4, the first index with `req` high wins.
- IDLE:
  - If any `req` is high, go to GRANT at the next edge with the winner.
  - Set `burst_cnt`=1 and `ptr`=(winner+1) mod 4.
  - Otherwise stay in IDLE.
- GRANT, owner k: the tenure ends at an edge when `req[k]`=0 or `burst_cnt`==MAX_BURST. At that edge:
  - If any requester other than k has `req` high, grant passes directly to the pick winner with no idle cycle. `burst_cnt`=1 and `ptr` advances past the new owner.
  - Otherwise, if `req[k]` is still high (burst expired, no competitor), k is re-granted for a new tenure with `burst_cnt`=1.
  - Otherwise, go to IDLE and clear all outputs.
- GRANT, tenure not ending: hold the owner and increment `burst_cnt`.
- A requester dropping `req` while it is not the owner has no effect.
- Requests newly raised mid-tenure are considered only at the tenure-end edge.
- Recovery: if the `grant` register is ever neither zero nor one-hot, the next edge returns the block to IDLE with reset values. `ptr` is preserved.

## Timing
- Request to grant latency is 1 cycle from IDLE: `req` sampled at edge N gives `grant` valid after edge N.
- Owner release latency is 1 cycle: `req[k]` low at edge N deasserts `grant[k]` after edge N.
- Handover is back-to-back. The old and new owner never overlap and there is no gap cycle.
- `grant`, `grant_idx`, `grant_valid` and `burst_cnt` are all flop outputs with no combinational path from `req`.
- With `MAX_BURST`=1, grant rotates every cycle among the active requesters.
- Deasserting `reset_n` mid-tenure clears `grant` immediately, asynchronously, without waiting for a clock edge.
- Operation resumes on the first rising edge after `reset_n` is released.
- Fairness bound: a continuously requesting requester is granted within 3×MAX_BURST+1 cycles.

## Structure
- Package `rr_arb_pkg` holds:
  - the state constants IDLE and GRANT;
  - the requester count NREQ=4;
  - the one-hot grant constants GNT0..GNT3;
  - a one-hot-to-index function.
- Sub-module `rr_pick` is purely combinational:
  - inputs `req[3:0]`, `ptr[1:0]`, and an exclude mask;
  - outputs `win_onehot[3:0]`, `win_idx[1:0]`, `any`.
- The top level holds the FSM, the burst counter, `ptr`, and the output registers.

## Test plan
- Reset with `req`=4'b1111 held → all outputs 0 while `reset_n`=0. After release, `grant`=0001 at the first edge and `ptr`=1.
- `req`=4'b1111 constant, MAX_BURST=4 → grant sequence is 0001×4, 0010×4, 0100×4, 1000×4, repeating, with `burst_cnt` counting 1..4 in each tenure.
- Only `req[2]` high for 10 cycles, MAX_BURST=4 → `grant`=0100 continuously, and `burst_cnt` runs 1,2,3,4,1,2,3,4,1,2 (re-grant with no gap).
- Owner 1 drops `req` after 2 cycles while `req[3]` is high → the next edge gives `grant`=1000 with no zero cycle. Then all `req` low → IDLE on the following edge with `grant`=0.
- `reset_n` pulsed low mid-tenure, between clock edges → `grant` clears immediately. After release it restarts from `ptr`=0.
- Force `grant`=0110 via the bench → the next edge returns to IDLE with `grant`=0 and `ptr` unchanged.
